// File: rtl/acc_bank_pkg.sv
// -----------------------------------------------------------------------------
// acc_bank_pkg
//   Shared definitions for the multi-channel accumulator bank:
//     - read-select codes for the readback port
//     - FSM state encoding for the clear sweep
//     - helper that sizes the read-select field
//   No ports (package).
// -----------------------------------------------------------------------------
package acc_bank_pkg;

    // Read-select codes. Codes SEL_ACC0 .. SEL_ACC0+NSLICE-1 pick accumulator
    // slices, least-significant slice first.
    localparam int SEL_COUNT = 0;
    localparam int SEL_FLAGS = 1;
    localparam int SEL_ACC0  = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Width of rd_sel: count + flags + one code per accumulator slice.
    function automatic int sel_w(input int nslice);
        return $clog2(nslice + 2);
    endfunction

endpackage

// File: rtl/acc_bank_channel.sv
// -----------------------------------------------------------------------------
// acc_bank_channel
//   One accumulator channel: ACC_W accumulator, CNT_W add counter, sticky
//   carry (counter wrapped) and sticky ovf flags.
//   Build option SATURATE_EN: when defined the accumulator clamps at all-ones
//   and ovf marks a clamp; otherwise it wraps and ovf marks the carry-out.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-low
//   add_en    in   add add_data into this channel this edge
//   add_data  in   ACC_W operand (already zero-extended)
//   clr_en    in   zero acc/cnt/carry/ovf this edge (wins over add_en)
//   acc       out  accumulator value
//   cnt       out  add counter
//   carry     out  sticky counter-wrap flag
//   ovf       out  sticky overflow flag
// -----------------------------------------------------------------------------
module acc_bank_channel
    import acc_bank_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             add_en,
    input  logic [ACC_W-1:0] add_data,
    input  logic             clr_en,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] cnt,
    output logic             carry,
    output logic             ovf
);

    // One extra bit holds the carry-out of the accumulator add.
    logic [ACC_W:0] sum;
    logic           cnt_wrap;

    assign sum      = {1'b0, acc} + {1'b0, add_data};
    assign cnt_wrap = &cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset is tested inside the clocked block (synchronous).
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr_en) begin
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (add_en) begin
            cnt <= cnt + 1'b1;
            if (cnt_wrap) begin
                carry <= 1'b1;
            end
            // Carry-out and "would clamp" are the same condition.
            if (sum[ACC_W]) begin
                ovf <= 1'b1;
            end
`ifdef SATURATE_EN
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
            acc <= sum[ACC_W-1:0];
`endif
        end
    end

endmodule

// File: rtl/acc_bank.sv
// -----------------------------------------------------------------------------
// acc_bank
//   Multi-channel adder/accumulator with a valid/ready operand stream.
//   Stage 1 registers the accepted operand (op_reg); stage 2 adds it into the
//   selected channel. A clear_all request runs a sweep that zeroes one channel
//   per cycle. Reads are registered and return one OUT_W-wide field.
//   Build option SATURATE_EN: accumulators clamp instead of wrapping
//   (see acc_bank_channel).
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-low
//   in_valid    in   operand valid
//   in_ready    out  operand accepted when in_valid & in_ready
//   data_in     in   DATA_W operand
//   ch_in       in   target channel of the operand
//   clear_all   in   request to zero every channel (honoured in IDLE only)
//   clear_done  out  pulse during the last sweep cycle
//   rd_en       in   read request
//   rd_ch       in   channel to read
//   rd_sel      in   0=count, 1={ovf,carry}, 2..NSLICE+1=acc slice
//   rd_valid    out  data_out valid, one cycle after rd_en
//   data_out    out  registered read data (holds when rd_en=0)
// -----------------------------------------------------------------------------
module acc_bank
    import acc_bank_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ACC_W  = 16,
    parameter  int CNT_W  = 8,
    parameter  int NUM_CH = 4,
    parameter  int OUT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH),
    localparam int NSLICE = ACC_W / OUT_W,
    localparam int SEL_W  = sel_w(NSLICE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CH_W-1:0]   ch_in,
    input  logic              clear_all,
    output logic              clear_done,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_valid,
    output logic [OUT_W-1:0]  data_out
);

    typedef struct packed {
        logic              valid;
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } op_t;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   sweep_idx;
    logic              sweep_last;
    op_t               op_reg;
    logic              accept;

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] carry_q;
    logic [NUM_CH-1:0] ovf_q;

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    assign sweep_last = (sweep_idx == CH_W'(NUM_CH - 1));

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        clear_done = 1'b0;
        case (state)
            ST_IDLE: begin
                // Drop ready as soon as the clear is requested so nothing new
                // enters op_reg behind the sweep.
                in_ready = !clear_all;
                if (clear_all) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear_done = sweep_last;
                if (sweep_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR && !sweep_last) begin
                sweep_idx <= sweep_idx + 1'b1;
            end else begin
                sweep_idx <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: operand register. An op captured before clear_all commits
    // on the same edge the FSM enters CLEAR, i.e. ahead of the sweep.
    // ------------------------------------------------------------------
    assign accept = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            op_reg <= '0;
        end else begin
            op_reg.valid <= accept;
            op_reg.ch    <= ch_in;
            op_reg.data  <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: channel bank
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic add_en;
        logic clr_en;

        assign add_en = op_reg.valid && (op_reg.ch == CH_W'(k));
        assign clr_en = (state == ST_CLEAR) && (sweep_idx == CH_W'(k));

        acc_bank_channel #(
            .ACC_W (ACC_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .add_en   (add_en),
            .add_data (ACC_W'(op_reg.data)),
            .clr_en   (clr_en),
            .acc      (acc_q[k]),
            .cnt      (cnt_q[k]),
            .carry    (carry_q[k]),
            .ovf      (ovf_q[k])
        );
    end

    // ------------------------------------------------------------------
    // Read mux and output register. The mux looks at the channel state
    // before this edge's update, so a same-edge add or clear is not seen.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0]       rd_word;
    logic [ACC_W-1:0]       rd_acc;
    logic [CNT_W+OUT_W-1:0] cnt_ext;
    logic [OUT_W+1:0]       flag_ext;

    always_comb begin
        rd_word  = '0;
        rd_acc   = '0;
        cnt_ext  = '0;
        flag_ext = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_ch == CH_W'(k)) begin
                rd_acc   = acc_q[k];
                cnt_ext  = {{OUT_W{1'b0}}, cnt_q[k]};
                flag_ext = {{OUT_W{1'b0}}, ovf_q[k], carry_q[k]};
            end
        end
        if (int'(rd_sel) == SEL_COUNT) begin
            rd_word = cnt_ext[OUT_W-1:0];
        end else if (int'(rd_sel) == SEL_FLAGS) begin
            rd_word = flag_ext[OUT_W-1:0];
        end else begin
            // Codes past the last slice fall through and read as zero.
            for (int s = 0; s < NSLICE; s++) begin
                if (int'(rd_sel) == SEL_ACC0 + s) begin
                    rd_word = rd_acc[s*OUT_W +: OUT_W];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            data_out <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                data_out <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// -----------------------------------------------------------------------------
// tb_acc_bank
//   Directed bench for acc_bank. A transaction-level model of the bank
//   (per-channel integers plus a pending-op queue and a sweep position) runs
//   alongside the DUT; every cycle its predictions for in_ready, clear_done,
//   rd_valid and data_out are compared. Hand-computed literals pin the model.
//   Honours SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acc_bank;
    import acc_bank_pkg::*;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 8;
    localparam int NUM_CH = 4;
    localparam int OUT_W  = 8;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int NSLICE = ACC_W / OUT_W;
    localparam int SEL_W  = sel_w(NSLICE);
    localparam int AMAX   = (1 << ACC_W) - 1;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [CH_W-1:0]   ch_in;
    logic              clear_all;
    logic              clear_done;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [SEL_W-1:0]  rd_sel;
    logic              rd_valid;
    logic [OUT_W-1:0]  data_out;

    acc_bank #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W),
        .NUM_CH (NUM_CH),
        .OUT_W  (OUT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .ch_in      (ch_in),
        .clear_all  (clear_all),
        .clear_done (clear_done),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .rd_sel     (rd_sel),
        .rd_valid   (rd_valid),
        .data_out   (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int ch;
        int data;
    } op_s;

    int  m_acc   [NUM_CH];
    int  m_cnt   [NUM_CH];
    int  m_carry [NUM_CH];
    int  m_ovf   [NUM_CH];
    op_s pend[$];
    int  m_clear_k = -1;            // sweep position, -1 when not clearing
    logic             exp_rd_valid = 1'b0;
    logic [OUT_W-1:0] exp_data     = '0;

    function automatic int model_read(input int ch, input int sel);
        if (sel == SEL_COUNT) return m_cnt[ch];
        if (sel == SEL_FLAGS) return m_ovf[ch] * 2 + m_carry[ch];
        if (sel >= SEL_ACC0 && sel < SEL_ACC0 + NSLICE)
            return (m_acc[ch] >> (OUT_W * (sel - SEL_ACC0))) & ((1 << OUT_W) - 1);
        return 0;
    endfunction

    function automatic void model_add(input int ch, input int data);
        int sum;
        sum = m_acc[ch] + data;
`ifdef SATURATE_EN
        if (sum > AMAX) begin
            m_acc[ch] = AMAX;
            m_ovf[ch] = 1;
        end else begin
            m_acc[ch] = sum;
        end
`else
        if (sum > AMAX) m_ovf[ch] = 1;
        m_acc[ch] = sum & AMAX;
`endif
        if (m_cnt[ch] == CMAX) m_carry[ch] = 1;
        m_cnt[ch] = (m_cnt[ch] + 1) & CMAX;
    endfunction

    function automatic void model_zero(input int ch);
        m_acc[ch]   = 0;
        m_cnt[ch]   = 0;
        m_carry[ch] = 0;
        m_ovf[ch]   = 0;
    endfunction

    always @(posedge clock) begin
        op_s o;
        bit  busy;
        bit  ready;
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) model_zero(k);
            pend.delete();
            m_clear_k    = -1;
            exp_rd_valid = 1'b0;
            exp_data     = '0;
        end else begin
            // Read sees the bank as it stood before this edge.
            exp_rd_valid = rd_en;
            if (rd_en) exp_data = OUT_W'(model_read(int'(rd_ch), int'(rd_sel)));
            // Ops accepted on the previous edge land now.
            while (pend.size() > 0) begin
                o = pend.pop_front();
                model_add(o.ch, o.data);
            end
            busy  = (m_clear_k >= 0);
            ready = !busy && !clear_all;
            if (busy) begin
                model_zero(m_clear_k);
                m_clear_k++;
                if (m_clear_k == NUM_CH) m_clear_k = -1;
            end else if (clear_all) begin
                m_clear_k = 0;
            end
            if (in_valid && ready) pend.push_back('{int'(ch_in), int'(data_in)});
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        #1;
        check("in_ready",   in_ready,   (m_clear_k < 0) && !clear_all);
        check("clear_done", clear_done, m_clear_k == NUM_CH - 1);
        check("rd_valid",   rd_valid,   exp_rd_valid);
        check("data_out",   data_out,   exp_data);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic push(input int ch, input int data);
        @(negedge clock);
        in_valid = 1'b1;
        ch_in    = CH_W'(ch);
        data_in  = DATA_W'(data);
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid  = 1'b0;
            rd_en     = 1'b0;
            clear_all = 1'b0;
        end
    endtask

    task automatic read_chk(input string name, input int ch, input int sel, input int exp);
        @(negedge clock);
        in_valid = 1'b0;
        rd_en    = 1'b1;
        rd_ch    = CH_W'(ch);
        rd_sel   = SEL_W'(sel);
        @(negedge clock);
        rd_en = 1'b0;
        #1 check(name, data_out, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        ch_in     = '0;
        clear_all = 1'b0;
        rd_en     = 1'b0;
        rd_ch     = '0;
        rd_sel    = '0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("rst data_out",   data_out,   0);
        check("rst rd_valid",   rd_valid,   0);
        check("rst clear_done", clear_done, 0);
        @(negedge clock);
        reset = 1'b1;
        #1 check("ready after reset", in_ready, 1);

        // 1: two adds into ch0
        push(0, 8'h05);
        push(0, 8'h07);
        quiet(2);
        read_chk("t1 slice0", 0, SEL_ACC0,     8'h0C);
        read_chk("t1 slice1", 0, SEL_ACC0 + 1, 8'h00);
        read_chk("t1 count",  0, SEL_COUNT,    2);
        read_chk("t1 flags",  0, SEL_FLAGS,    0);

        // 2: 256 back-to-back adds of 1 into ch1 wrap the counter
        for (int i = 0; i < 256; i++) push(1, 8'h01);
        quiet(2);
        read_chk("t2 count",  1, SEL_COUNT,    8'h00);
        read_chk("t2 flags",  1, SEL_FLAGS,    1);
        read_chk("t2 slice0", 1, SEL_ACC0,     8'h00);
        read_chk("t2 slice1", 1, SEL_ACC0 + 1, 8'h01);
        read_chk("t2 ch0 kept", 0, SEL_ACC0,   8'h0C);
        read_chk("t2 ch2 kept", 2, SEL_COUNT,  0);

        // 3: preload ch2 to 0xFFF0 (256*0xFF + 0xF0), then add 0x20
        for (int i = 0; i < 256; i++) push(2, 8'hFF);
        push(2, 8'hF0);
        quiet(2);
        read_chk("t3 pre slice0", 2, SEL_ACC0,     8'hF0);
        read_chk("t3 pre slice1", 2, SEL_ACC0 + 1, 8'hFF);
        read_chk("t3 pre flags",  2, SEL_FLAGS,    1);
        push(2, 8'h20);
        quiet(2);
`ifdef SATURATE_EN
        read_chk("t3 slice0", 2, SEL_ACC0,     8'hFF);
        read_chk("t3 slice1", 2, SEL_ACC0 + 1, 8'hFF);
`else
        read_chk("t3 slice0", 2, SEL_ACC0,     8'h10);
        read_chk("t3 slice1", 2, SEL_ACC0 + 1, 8'h00);
`endif
        read_chk("t3 flags", 2, SEL_FLAGS, 3);
        read_chk("t3 count", 2, SEL_COUNT, 2);

        // 4: op sitting in op_reg when clear_all arrives
        push(0, 8'h03);
        @(negedge clock);
        in_valid  = 1'b0;
        clear_all = 1'b1;
        #1 check("t4 ready on req", in_ready, 0);
        @(negedge clock);                      // sweep cycle 0, read ch0 before it clears
        clear_all = 1'b0;
        rd_en     = 1'b1;
        rd_ch     = CH_W'(0);
        rd_sel    = SEL_W'(SEL_ACC0);
        #1;
        check("t4 ready sw0", in_ready,   0);
        check("t4 done sw0",  clear_done, 0);
        @(negedge clock);                      // sweep cycle 1
        rd_en = 1'b0;
        #1;
        check("t4 op committed", data_out, 8'h0F);
        check("t4 ready sw1",    in_ready,   0);
        check("t4 done sw1",     clear_done, 0);
        @(negedge clock);                      // sweep cycle 2
        #1;
        check("t4 ready sw2", in_ready,   0);
        check("t4 done sw2",  clear_done, 0);
        @(negedge clock);                      // sweep cycle 3
        #1;
        check("t4 ready sw3", in_ready,   0);
        check("t4 done sw3",  clear_done, 1);
        @(negedge clock);
        #1;
        check("t4 ready idle", in_ready,   1);
        check("t4 done idle",  clear_done, 0);
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < NSLICE + 2; s++)
                read_chk("t4 cleared", c, s, 0);

        // 5: read ch3 on the same edge an add commits to it
        push(3, 8'h22);
        quiet(2);
        push(3, 8'h10);
        @(negedge clock);
        in_valid = 1'b0;
        rd_en    = 1'b1;
        rd_ch    = CH_W'(3);
        rd_sel   = SEL_W'(SEL_ACC0);
        @(negedge clock);
        rd_en = 1'b0;
        #1 check("t5 old value", data_out, 8'h22);
        quiet(1);
        read_chk("t5 new value", 3, SEL_ACC0, 8'h32);

        // 6: reset in the middle of a sweep
        @(negedge clock);
        clear_all = 1'b1;
        @(negedge clock);                      // sweep cycle 0
        clear_all = 1'b0;
        #1 check("t6 done sw0", clear_done, 0);
        @(negedge clock);                      // sweep cycle 1
        reset = 1'b0;
        #1 check("t6 done sw1", clear_done, 0);
        repeat (2) begin
            @(negedge clock);
            #1 check("t6 done in reset", clear_done, 0);
        end
        @(negedge clock);
        reset = 1'b1;
        #1 check("t6 ready after release", in_ready, 1);
        repeat (4) begin
            @(negedge clock);
            #1 check("t6 no late done", clear_done, 0);
        end
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < NSLICE + 2; s++)
                read_chk("t6 zero", c, s, 0);

        quiet(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
